// File: rtl/mat_pkg.sv
// Shared definitions for the 5x5 x 8-bit matrix add/subtract subsystem.
package mat_pkg;

    localparam int ELEM_W   = 8;
    localparam int ELEM_CNT = 25;
    localparam int MAT_W    = ELEM_W * ELEM_CNT;

    // 3'b010..3'b111 are reserved for future multiply/transpose commands.
    localparam logic [2:0] OP_ADD = 3'b000;
    localparam logic [2:0] OP_SUB = 3'b001;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        DONE = 2'd2
    } state_t;

    function automatic logic op_supported(input logic [2:0] op);
        return (op == OP_ADD) || (op == OP_SUB);
    endfunction

endpackage

// File: rtl/matrix_op_sequencer.sv
// Command-level controller for the matrix add/subtract datapath: accepts one
// command, drives the datapath operands, waits out its latency, and holds the
// captured result behind a done/ack handshake.
module matrix_op_sequencer
    import mat_pkg::*;
#(
    parameter int MAT_W      = mat_pkg::MAT_W,
    parameter int DP_LATENCY = 1,
    parameter int CNT_W      = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [2:0]       op,
    input  logic [MAT_W-1:0] mat_a_in,
    input  logic [MAT_W-1:0] mat_b_in,
    input  logic             ack,
    output logic             busy,
    output logic             done,
    output logic [MAT_W-1:0] result,
    output logic             overflow,
    output logic             err,
    output logic             cmd_drop,
    output logic [MAT_W-1:0] dp_mat_a,
    output logic [MAT_W-1:0] dp_mat_b,
    output logic             dp_select,
    input  logic [MAT_W-1:0] dp_mat_out,
    input  logic             dp_overflow
);

    state_t           state;
    state_t           state_next;
    logic [CNT_W-1:0] count;
    logic             accept;

    // A command is only taken while idle; starts anywhere else are dropped.
    assign accept = (state == IDLE) && start;

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state logic: unsupported opcodes skip EXEC and complete at once.
    always_comb begin
        state_next = state;
        case (state)
            IDLE: begin
                if (start) begin
                    state_next = op_supported(op) ? EXEC : DONE;
                end
            end
            EXEC: begin
                if (count == '0) begin
                    state_next = DONE;
                end
            end
            DONE: begin
                if (ack) begin
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    // Status outputs decode directly from the state register.
    always_comb begin
        busy = (state != IDLE);
        done = (state == DONE);
    end

    // Operand latch, latency counter, result capture and sticky drop flag.
    // The counter starts at DP_LATENCY so EXEC spans DP_LATENCY+1 cycles:
    // one for the datapath's negate/mux to settle plus its output register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count     <= '0;
            dp_mat_a  <= '0;
            dp_mat_b  <= '0;
            dp_select <= 1'b0;
            result    <= '0;
            overflow  <= 1'b0;
            err       <= 1'b0;
            cmd_drop  <= 1'b0;
        end else begin
            if (accept) begin
                dp_mat_a  <= mat_a_in;
                dp_mat_b  <= mat_b_in;
                dp_select <= op[0];
                result    <= '0;
                overflow  <= 1'b0;
                err       <= !op_supported(op);
                cmd_drop  <= 1'b0;
                count     <= CNT_W'(DP_LATENCY);
            end else if (start) begin
                cmd_drop  <= 1'b1;
            end

            if (state == EXEC) begin
                if (count == '0) begin
                    result   <= dp_mat_out;
                    overflow <= dp_overflow;
                end else begin
                    count    <= count - 1'b1;
                end
            end
        end
    end

endmodule

// File: tb/tb_matrix_op_sequencer.sv
// Randomized scoreboard bench for matrix_op_sequencer with a behavioural
// add/sub datapath model hanging off the dp_* ports.
module tb_matrix_op_sequencer;
    import mat_pkg::*;

    localparam int DPL = 1;
    localparam int W   = 200;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         start = 1'b0;
    logic [2:0]   op = 3'b000;
    logic [W-1:0] mat_a_in = '0;
    logic [W-1:0] mat_b_in = '0;
    logic         ack = 1'b0;
    logic         busy, done, overflow, err, cmd_drop, dp_select;
    logic [W-1:0] result, dp_mat_a, dp_mat_b;
    logic [W-1:0] dp_mat_out = '0;
    logic         dp_overflow = 1'b0;
    logic         garbage = 1'b0;

    typedef struct {
        logic [W-1:0] res;
        logic         ovf;
        logic         err;
    } exp_t;

    exp_t sb[$];
    exp_t cur;
    int   total = 0;
    int   bad = 0;
    logic done_q = 1'b0;

    always #5 clk = ~clk;

    matrix_op_sequencer #(.MAT_W(W), .DP_LATENCY(DPL), .CNT_W(4)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .op(op),
        .mat_a_in(mat_a_in), .mat_b_in(mat_b_in), .ack(ack),
        .busy(busy), .done(done), .result(result), .overflow(overflow),
        .err(err), .cmd_drop(cmd_drop), .dp_mat_a(dp_mat_a),
        .dp_mat_b(dp_mat_b), .dp_select(dp_select),
        .dp_mat_out(dp_mat_out), .dp_overflow(dp_overflow)
    );

    function automatic void chk(string nm, logic [W-1:0] act, logic [W-1:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endfunction

    // Element-wise signed add/sub; overflow if any element leaves [-128,127]
    // or, for subtract, if negating B itself overflows (B element = -128).
    function automatic void ref_op(input logic [W-1:0] a, input logic [W-1:0] b,
                                   input logic sub, output logic [W-1:0] r,
                                   output logic ov);
        r  = '0;
        ov = 1'b0;
        for (int e = 0; e < 25; e++) begin
            int ai;
            int bi;
            int s;
            ai = int'($signed(a[e*8 +: 8]));
            bi = int'($signed(b[e*8 +: 8]));
            if (sub) begin
                if (bi == -128) ov = 1'b1;
                s = ai - bi;
            end else begin
                s = ai + bi;
            end
            if (s > 127 || s < -128) ov = 1'b1;
            r[e*8 +: 8] = s[7:0];
        end
    endfunction

    function automatic logic [W-1:0] rand_mat();
        logic [W-1:0] r;
        r = '0;
        for (int e = 0; e < 25; e++) r[e*8 +: 8] = 8'($urandom);
        return r;
    endfunction

    // Datapath model: one registered stage; garbage mode scrambles its output.
    always @(posedge clk) begin : dp_model
        logic [W-1:0] r;
        logic         ov;
        if (garbage) begin
            r  = rand_mat();
            ov = 1'($urandom);
        end else begin
            ref_op(dp_mat_a, dp_mat_b, dp_select, r, ov);
        end
        dp_mat_out  <= r;
        dp_overflow <= ov;
    end

    // Monitor: pop on each rising done, then verify the result stays held.
    always @(negedge clk) begin
        if (!rst_n) begin
            done_q = 1'b0;
        end else begin
            if (done && !done_q) begin
                if (sb.size() == 0) begin
                    total++;
                    bad++;
                    $display("FAIL unexpected_done: got done=1 required no pending command");
                end else begin
                    cur = sb.pop_front();
                    chk("result", result, cur.res);
                    chk("overflow", W'(overflow), W'(cur.ovf));
                    chk("err", W'(err), W'(cur.err));
                end
            end else if (done) begin
                chk("held_result", result, cur.res);
                chk("held_overflow", W'(overflow), W'(cur.ovf));
                chk("held_err", W'(err), W'(cur.err));
            end
            done_q = done;
        end
    end

    task automatic chk_reset(string tag);
        chk({tag, "_busy"}, W'(busy), '0);
        chk({tag, "_done"}, W'(done), '0);
        chk({tag, "_result"}, result, '0);
        chk({tag, "_overflow"}, W'(overflow), '0);
        chk({tag, "_err"}, W'(err), '0);
        chk({tag, "_cmd_drop"}, W'(cmd_drop), '0);
        chk({tag, "_dp_mat_a"}, dp_mat_a, '0);
        chk({tag, "_dp_mat_b"}, dp_mat_b, '0);
        chk({tag, "_dp_select"}, W'(dp_select), '0);
    endtask

    // Issue a command from IDLE and wait for done; optionally pulse start
    // during the first EXEC cycle to provoke a drop.
    task automatic issue(input logic [W-1:0] a, input logic [W-1:0] b,
                         input logic [2:0] op_v, input bit collide);
        exp_t e;
        int   lat;
        int   exp_lat;
        logic sup;
        sup = (op_v == 3'b000) || (op_v == 3'b001);
        if (sup) begin
            ref_op(a, b, op_v[0], e.res, e.ovf);
            e.err   = 1'b0;
            exp_lat = DPL + 2;
        end else begin
            e.res   = '0;
            e.ovf   = 1'b0;
            e.err   = 1'b1;
            exp_lat = 1;
        end
        @(negedge clk);
        mat_a_in = a;
        mat_b_in = b;
        op       = op_v;
        start    = 1'b1;
        sb.push_back(e);
        @(negedge clk);
        start = 1'b0;
        chk("latched_a", dp_mat_a, a);
        chk("latched_b", dp_mat_b, b);
        chk("dp_select", W'(dp_select), W'(op_v[0]));
        chk("cmd_drop_cleared", W'(cmd_drop), '0);
        chk("busy_after_accept", W'(busy), W'(1'b1));
        lat = 1;
        if (collide && sup) begin
            start    = 1'b1;
            op       = 3'($urandom);
            mat_a_in = rand_mat();
            @(negedge clk);
            start = 1'b0;
            lat++;
            chk("cmd_drop_exec", W'(cmd_drop), W'(1'b1));
        end
        while (!done && lat < 50) begin
            @(negedge clk);
            lat++;
        end
        chk("latency", W'(lat), W'(exp_lat));
        $display("cmd op=%0d a0=%h b0=%h latency=%0d result0=%h ovf=%0d err=%0d",
                 op_v, a[7:0], b[7:0], lat, result[7:0], overflow, err);
    endtask

    task automatic do_ack();
        ack = 1'b1;
        @(negedge clk);
        ack = 1'b0;
        chk("done_after_ack", W'(done), '0);
        chk("busy_after_ack", W'(busy), '0);
    endtask

    initial begin
        logic [W-1:0] a;
        logic [W-1:0] b;

        // Reset held with inputs toggling, including start.
        start    = 1'b1;
        mat_a_in = rand_mat();
        mat_b_in = rand_mat();
        ack      = 1'b1;
        repeat (3) @(negedge clk);
        chk_reset("rst_hold");
        start = 1'b0;
        ack   = 1'b0;
        rst_n = 1'b1;
        @(negedge clk);
        chk_reset("rst_release");

        // ADD: 5 + 3 everywhere.
        issue({25{8'h05}}, {25{8'h03}}, OP_ADD, 1'b0);
        do_ack();

        // SUB with element overflow: -128 - 1.
        a = '0; a[7:0] = 8'h80;
        b = '0; b[7:0] = 8'h01;
        issue(a, b, OP_SUB, 1'b0);
        chk("sub_elem0", W'(result[7:0]), W'(8'h7F));
        chk("sub_ovf", W'(overflow), W'(1'b1));
        do_ack();

        // Unsupported opcode completes directly with err.
        issue(rand_mat(), rand_mat(), 3'b101, 1'b0);
        do_ack();

        // Collisions in EXEC and DONE, then start+ack together.
        issue(rand_mat(), rand_mat(), OP_ADD, 1'b1);
        start = 1'b1;
        op    = OP_SUB;
        @(negedge clk);
        start = 1'b0;
        chk("cmd_drop_done", W'(cmd_drop), W'(1'b1));
        chk("done_kept", W'(done), W'(1'b1));
        start = 1'b1;
        do_ack();
        start = 1'b0;
        chk("cmd_drop_start_ack", W'(cmd_drop), W'(1'b1));
        @(negedge clk);
        chk("no_back_to_back", W'(busy), '0);

        // Held result while inputs and datapath output churn.
        a = rand_mat();
        issue(a, rand_mat(), OP_SUB, 1'b0);
        garbage = 1'b1;
        repeat (10) begin
            mat_a_in = rand_mat();
            @(negedge clk);
        end
        garbage = 1'b0;
        chk("dp_a_held", dp_mat_a, a);
        do_ack();

        // Randomized commands.
        for (int i = 0; i < 16; i++) begin
            logic [2:0] o;
            o = ($urandom_range(0, 3) == 3) ? 3'($urandom_range(2, 7))
                                            : 3'($urandom_range(0, 1));
            issue(rand_mat(), rand_mat(), o, 1'($urandom_range(0, 1)));
            repeat ($urandom_range(0, 3)) @(negedge clk);
            do_ack();
        end

        // Reset during EXEC aborts the command; done must never rise.
        @(negedge clk);
        mat_a_in = rand_mat();
        mat_b_in = rand_mat();
        op       = OP_ADD;
        start    = 1'b1;
        @(negedge clk);
        start = 1'b0;
        #1 rst_n = 1'b0;
        #1 chk_reset("rst_exec");
        repeat (4) begin
            @(negedge clk);
            chk("done_during_reset", W'(done), '0);
        end
        rst_n = 1'b1;
        repeat (4) begin
            @(negedge clk);
            chk("done_after_abort", W'(done), '0);
        end

        chk("scoreboard_empty", W'(sb.size()), '0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/matrix_op_sequencer.md
Name: matrix_op_sequencer

Overview:
- Command-level controller for the 5x5 x 8-bit matrix add/subtract datapath (200-bit operand buses, registered sum stage).
- Accepts one command from the HPS-facing register bridge, latches operands, and drives the datapath's A, B and select inputs.
- Waits out the datapath latency, captures result and overflow, and holds them behind a done/ack handshake.
- Sits between the bridge registers and the add/sub datapath instance; the datapath has no handshake of its own.

Parameters:
MAT_W, 200, total matrix bus width (25 elements x 8 bits)
DP_LATENCY, 1, clock cycles from a stable datapath input to a valid registered datapath output
CNT_W, 4, latency counter width; must satisfy 2^CNT_W > DP_LATENCY

Ports:
clk  in  1  system clock, rising edge
rst_n  in  1  asynchronous active-low reset
start  in  1  command strobe; sampled only in IDLE
op  in  3  opcode: 3'b000 ADD, 3'b001 SUB, all others unsupported
mat_a_in  in  MAT_W  operand A from the bridge
mat_b_in  in  MAT_W  operand B from the bridge
ack  in  1  host acknowledge of a completed result
busy  out  1  high whenever state is not IDLE
done  out  1  result and flags valid; held until ack
result  out  MAT_W  captured matrix result
overflow  out  1  captured datapath overflow
err  out  1  unsupported opcode on the last command
cmd_drop  out  1  sticky: a start arrived while busy
dp_mat_a  out  MAT_W  registered operand A to the datapath
dp_mat_b  out  MAT_W  registered operand B to the datapath
dp_select  out  1  0 = add, 1 = subtract
dp_mat_out  in  MAT_W  datapath result
dp_overflow  in  1  datapath overflow

Behaviour:
- Reset, asynchronous on rst_n low: state IDLE.
  - All outputs 0: busy, done, result, overflow, err, cmd_drop, dp_mat_a, dp_mat_b, dp_select.
  - Counter 0.
  - Reset mid-operation aborts the command; no done is issued.
- States: IDLE, EXEC, DONE.
- IDLE with start=1, cycle N:
  - Latch mat_a_in into dp_mat_a and mat_b_in into dp_mat_b.
  - dp_select = op[0].
  - Clear err, overflow and cmd_drop.
  - Supported op: go to EXEC; counter = DP_LATENCY.
  - Unsupported op: go directly to DONE with err=1, result=0, overflow=0; dp_* registers still update.
- EXEC:
  - Counter decrements each cycle.
  - Datapath inputs stay stable for the whole EXEC window.
  - When counter==0: capture dp_mat_out into result and dp_overflow into overflow, then go to DONE.
  - EXEC therefore lasts DP_LATENCY+1 cycles: one settle cycle for negation/mux plus the datapath register.
- Latency: start accepted at cycle N gives done=1 from cycle N+DP_LATENCY+2 (N+3 at the default).
- DONE:
  - done=1; result, overflow and err are held.
  - ack=1 goes to IDLE next cycle; done drops that cycle.
  - ack is ignored outside DONE.
- start outside IDLE:
  - The command is ignored and cmd_drop is set to 1.
  - cmd_drop stays set until the next accepted start.
  - start and ack together in DONE: ack is honoured, start is dropped and sets cmd_drop. There is no back-to-back accept.
- busy = (state != IDLE), registered with the state.
- dp_* outputs keep their last values in IDLE and DONE; they are not cleared after a command.
- Overflow semantics belong to the datapath: for SUB, its overflow already includes negation overflow (e.g. negating -128). The sequencer only captures it.

Decomposition:
- Shared package mat_pkg:
  - MAT_W, element width 8, element count 25.
  - Opcode constants OP_ADD=3'b000 and OP_SUB=3'b001, with 3'b010..3'b111 reserved for future multiply/transpose.
  - State enum: IDLE, EXEC, DONE.
- No sub-module; the latency counter is inline.
- The add/sub datapath is instantiated beside this block at top level, not inside it.

Test Plan:
- Reset: hold rst_n=0 while outputs are driven, release -> all outputs 0, busy=0. Assert rst_n=0 during EXEC -> immediate IDLE, done never rises.
- ADD: A all 8'h05, B all 8'h03, op=000, start at cycle N -> done rises at N+3, result all 8'h08, overflow=0, err=0. Then ack -> busy=0 the next cycle.
- SUB overflow: A element0=8'h80 (-128) and the rest 0, B element0=8'h01, op=001 -> dp_select=1, result element0=8'h7F, overflow=1.
- Unsupported op=3'b101 -> done at N+1 with err=1, result=0, and no EXEC cycles observed on busy.
- Busy collision: pulse start during EXEC and again during DONE -> cmd_drop=1 and the original result is unchanged. The next accepted start clears cmd_drop.
- Held result: delay ack 10 cycles while changing mat_a_in and dp_mat_out -> result, overflow and done stay stable until ack.
